// File: rtl/chase_pkg.sv
// chase_pkg: shared constants and types for the blob locator.
// Screen geometry, output widths and the blob FSM state type.
package chase_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int RAD_W    = 7;

  localparam logic [X_W-1:0]   OFFSCREEN_X = 9'h1FF;
  localparam logic [RAD_W-1:0] RAD_MAX     = '1;

  typedef enum logic [1:0] {
    ACCUM,
    DIVIDE,
    PUBLISH
  } blob_state_t;

  // Halve a blob extent and clamp it to the radius range.
  function automatic logic [RAD_W-1:0] rad_sat(
    input logic [X_W:0] ext
  );
    logic [X_W:0] half;
    half = ext >> 1;
    if (half > (X_W+1)'(RAD_MAX)) return RAD_MAX;
    return half[RAD_W-1:0];
  endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle.
// done pulses in the last iteration; quotient is valid with it.
module seq_divider #(
  parameter int DIV_W = 25,
  parameter int DSR_W = 17,
  parameter int Q_W   = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DSR_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CW = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] dvd_q, dvd_nx;
  logic [DSR_W-1:0] dsr_q, rem_q, rem_nx;
  logic [DSR_W:0]   shifted, diff;
  logic             qbit;
  logic [CW-1:0]    step_q;

  // One trial subtraction; quotient bits shift in behind the dividend.
  always_comb begin
    shifted  = {rem_q, dvd_q[DIV_W-1]};
    diff     = shifted - {1'b0, dsr_q};
    qbit     = ~diff[DSR_W];
    rem_nx   = qbit ? diff[DSR_W-1:0] : shifted[DSR_W-1:0];
    dvd_nx   = {dvd_q[DIV_W-2:0], qbit};
    done     = busy && (step_q == CW'(DIV_W - 1));
    quotient = dvd_nx[Q_W-1:0];
  end

  // Iteration registers; a start always reloads the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      step_q <= '0;
      rem_q  <= '0;
      dvd_q  <= dividend;
      dsr_q  <= divisor;
    end else if (busy) begin
      rem_q  <= rem_nx;
      dvd_q  <= dvd_nx;
      step_q <= step_q + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/blob_centroid.sv
// blob_centroid: per-frame blob centroid x and radius.
// Define BLOB_VERTICAL_RAD_EN to include blob height in the radius.
module blob_centroid
  import chase_pkg::*;
#(
  parameter int MIN_PIXELS = 16,
  parameter int DIV_W      = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic             pix_match,
  input  logic [X_W-1:0]   hcount,
  input  logic [Y_W-1:0]   vcount,
  input  logic             frame_done,
  output logic [X_W-1:0]   pre_x,
  output logic [RAD_W-1:0] pre_rad,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = 17;

  blob_state_t state_q, state_d;

  logic             hit, big, start;
  logic             div_busy, div_done;
  logic [DIV_W-1:0] sum_x, sum_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [X_W-1:0]   min_x, max_x, min_nx, max_nx;
  logic [X_W-1:0]   quot;
  logic [X_W:0]     width, ext;
  logic [RAD_W-1:0] rad_nx, rad_q;

`ifdef BLOB_VERTICAL_RAD_EN
  logic [Y_W-1:0] min_y, max_y, min_ny, max_ny;
  logic [Y_W:0]   height;

  // Vertical extent of this frame, including a same-cycle match.
  always_comb begin
    min_ny = min_y;
    max_ny = max_y;
    if (hit && vcount < min_y) min_ny = vcount;
    if (hit && vcount > max_y) max_ny = vcount;
    height = {1'b0, max_ny} - {1'b0, min_ny} + 1'b1;
  end

  // Vertical extent registers, cleared at every frame boundary.
  always_ff @(posedge clk) begin
    if (rst || frame_done) begin
      min_y <= '1;
      max_y <= '0;
    end else begin
      min_y <= min_ny;
      max_y <= max_ny;
    end
  end
`else
  logic unused_vcount;
  assign unused_vcount = ^vcount;
`endif

  // Next accumulator values and the radius they imply.
  always_comb begin
    hit    = pix_valid & pix_match;
    sum_nx = sum_x;
    cnt_nx = cnt;
    min_nx = min_x;
    max_nx = max_x;
    if (hit) begin
      sum_nx = sum_x + DIV_W'(hcount);
      cnt_nx = cnt + 1'b1;
      if (hcount < min_x) min_nx = hcount;
      if (hcount > max_x) max_nx = hcount;
    end
    width = {1'b0, max_nx} - {1'b0, min_nx} + 1'b1;
    ext   = width;
`ifdef BLOB_VERTICAL_RAD_EN
    if ({1'b0, height} > width) ext = {1'b0, height};
`endif
    rad_nx    = rad_sat(ext);
    big       = cnt_nx >= CNT_W'(MIN_PIXELS);
    start     = (state_q == ACCUM) && frame_done && big;
    overrun   = frame_done && (state_q != ACCUM);
    out_valid = (state_q == PUBLISH);
    busy      = div_busy;
  end

  // Frame accumulators; frame_done snapshots then clears them.
  always_ff @(posedge clk) begin
    if (rst || frame_done) begin
      sum_x <= '0;
      cnt   <= '0;
      min_x <= OFFSCREEN_X;
      max_x <= '0;
    end else begin
      sum_x <= sum_nx;
      cnt   <= cnt_nx;
      min_x <= min_nx;
      max_x <= max_nx;
    end
  end

  // Radius snapshot held while the divide runs.
  always_ff @(posedge clk) begin
    if (rst) rad_q <= '0;
    else if (start) rad_q <= rad_nx;
  end

  seq_divider #(
    .DIV_W (DIV_W),
    .DSR_W (CNT_W),
    .Q_W   (X_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (sum_nx),
    .divisor  (cnt_nx),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quot)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:
        if (frame_done) state_d = big ? DIVIDE : PUBLISH;
      DIVIDE:
        if (div_done) state_d = PUBLISH;
      PUBLISH:
        state_d = ACCUM;
      default:
        state_d = ACCUM;
    endcase
  end

  // Published outputs, loaded on entry to PUBLISH and held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_x   <= OFFSCREEN_X;
      pre_rad <= '0;
    end else if (state_q == ACCUM && frame_done && !big) begin
      pre_x   <= OFFSCREEN_X;
      pre_rad <= '0;
    end else if (state_q == DIVIDE && div_done) begin
      pre_x   <= quot;
      pre_rad <= rad_q;
    end
  end

endmodule

// File: doc/blob_centroid.md
# blob_centroid

Per-frame colour-blob locator that sits directly upstream of the x/radius hold-and-fallback stage. It consumes the thresholded pixel stream from the camera front end, accumulates horizontal position statistics over one frame, and at end of frame publishes a centroid x (`pre_x`) and a blob radius (`pre_rad`). When too few pixels match, it publishes the off-screen code `pre_x = 9'h1FF`.

## Interface

Parameters:

- `MIN_PIXELS`, default 16: minimum matching-pixel count for a valid blob.
- `DIV_W`, default 25: dividend width, sized for a 320×240 frame.

Ports:

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `pix_valid` in 1: the current pixel is inside the active 320×240 window.
- `pix_match` in 1: the current pixel passed colour thresholding.
- `hcount` in 9: pixel column, 0..319.
- `vcount` in 8: pixel row, 0..239.
- `frame_done` in 1: one-cycle pulse marking the last cycle of a frame.
- `pre_x` out 9: centroid column, or 9'h1FF when no blob.
- `pre_rad` out 7: blob half-width, saturating.
- `out_valid` out 1: one-cycle pulse when `pre_x`/`pre_rad` update.
- `busy` out 1: divider running.
- `overrun` out 1: one-cycle pulse when a `frame_done` result is dropped.

## Operation

- **Accumulators.** `sum_x` (25 b), `cnt` (17 b), `min_x`, `max_x` (9 b each).
  - Update on `pix_valid & pix_match`: add `hcount` to `sum_x`, increment `cnt`, and update `min_x`/`max_x`.
  - `min_x` resets to 9'h1FF and `max_x` to 0.
- **Frame boundary.**
  - On `frame_done`, the statistics are snapshotted. A match in the same cycle as `frame_done` is included in the snapshot.
  - The accumulators are then cleared for the next frame, which accumulates in parallel with the divide.
- **State machine: ACCUM → DIVIDE → PUBLISH → ACCUM.**
  - ACCUM + `frame_done` with `cnt_snap < MIN_PIXELS` → PUBLISH directly, with `pre_x = 9'h1FF`, `pre_rad = 0`.
  - ACCUM + `frame_done` with `cnt_snap ≥ MIN_PIXELS` → DIVIDE, starting a restoring divide of `sum_snap / cnt_snap`.
  - DIVIDE runs 25 cycles at 1 quotient bit per cycle, then → PUBLISH.
  - PUBLISH loads the outputs, pulses `out_valid`, then → ACCUM.
- **Arithmetic.**
  - The quotient is truncated. Its low 9 bits become `pre_x`, which is always ≤ 319.
  - `rad = (max_x − min_x + 1) >> 1`, saturated to 127.
- **Overrun.** A `frame_done` arriving in DIVIDE or PUBLISH:
  - That frame's snapshot is discarded.
  - `overrun` pulses in the same cycle.
  - Its accumulators are still cleared.
  - The in-flight result publishes normally.
- **Output hold.** `pre_x`/`pre_rad` hold their value between `out_valid` pulses.

## Timing

- **Reset values.**
  - Outputs: `pre_x = 9'h1FF`, `pre_rad = 0`, `out_valid = 0`, `busy = 0`, `overrun = 0`.
  - Internal: state ACCUM, accumulators cleared.
- **Latency**, with `frame_done` high in cycle N:
  - No-blob path: `out_valid` high in cycle N+1.
  - Blob path: `busy` is high in cycles N+1..N+25, and `out_valid` is high in cycle N+26 with the new outputs visible in that same cycle.
- **Reset mid-divide:**
  - The divide aborts and the state returns to ACCUM.
  - No `out_valid` is issued.
  - Outputs return to their reset values.
- **Ignored stimulus.** `pix_match` without `pix_valid` is ignored.

## Configuration

- Macro `BLOB_VERTICAL_RAD_EN`.
- **Defined:**
  - Additionally tracks `min_y`/`max_y` from `vcount`.
  - `rad = max(width, height) >> 1`, saturated to 127, where width = `max_x − min_x + 1` and height = `max_y − min_y + 1`.
- **Undefined:**
  - Width-only radius.
  - No y registers exist.

## Structure

- **Package `chase_pkg`:**
  - Constants: `SCREEN_W = 320`, `SCREEN_H = 240`, `X_W = 9`, `RAD_W = 7`, `OFFSCREEN_X = 9'h1FF`.
  - Typedef `blob_state_t` with states ACCUM, DIVIDE, PUBLISH.
- **Sub-module `seq_divider`:**
  - Parameterised restoring divider.
  - Control: start/done handshake; `done` is a one-cycle pulse after `DIV_W` cycles.
  - Data in: dividend `DIV_W`, divisor 17 b.
  - Data out: quotient.

## Test plan

- **Narrow blob.** Matches at x = 100..149 on rows 10..19 (500 px) → `pre_x = 124`, `pre_rad = 25`, `out_valid` exactly 26 cycles after `frame_done`.
- **No blob.** 5 matching pixels (below 16) → `pre_x = 9'h1FF`, `pre_rad = 0`, `out_valid` 1 cycle after `frame_done`, `busy` never high.
- **Full width.** Full-width rows, x = 0..319 → `pre_x = 159`, `pre_rad = 127` (saturated).
- **Overrun.** Second `frame_done` issued 10 cycles into DIVIDE → `overrun` pulses that cycle, first result still published, no second `out_valid`.
- **Reset mid-divide.** `rst` asserted at cycle 12 of DIVIDE → no `out_valid`, `pre_x = 9'h1FF`. The next frame, with x = 40..59 over 40 px, yields `pre_x = 49`, `pre_rad = 10`.
- **Vertical radius.** With `BLOB_VERTICAL_RAD_EN`: x = 100..109, y = 0..99 → `pre_rad = 50`. Without it → `pre_rad = 5`.
